// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the bus-ownership arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package bus_arb_pkg;

    // Transfer size carried alongside each master's address.
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } xfer_size_t;

    // OWNED: a master holds the bus. HANDOVER: the single dead cycle between owners.
    typedef enum logic {
        OWNED    = 1'b0,
        HANDOVER = 1'b1
    } arb_state_t;

    // Master that owns the bus when nobody else asks for it (the CPU).
    localparam int PARK_MASTER = 0;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner picker: any requesting DMA beats the CPU, else park at 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module arb_pick
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 5,
    parameter int RR_MODE     = 0,
    localparam int IDX_W      = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       rr_ptr,
    output logic [IDX_W-1:0]       winner,
    output logic                   any_dma
);

    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] cand;
    int               idx;
    logic             found;

    // Scan the DMA channels from the start point, wrapping N-1 -> 1.
    // Fixed priority is the same scan always starting at channel 1.
    always_comb begin
        winner  = IDX_W'(PARK_MASTER);
        any_dma = |req[NUM_MASTERS-1:1];
        start   = (RR_MODE != 0) ? rr_ptr : IDX_W'(1);
        cand    = '0;
        idx     = 0;
        found   = 1'b0;
        for (int off = 0; off < NUM_MASTERS - 1; off++) begin
            idx = int'(start) + off;
            if (idx > NUM_MASTERS - 1) begin
                idx = idx - (NUM_MASTERS - 1);
            end
            cand = IDX_W'(idx);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_master_arbiter.sv
// Bus-ownership arbiter: registered owner/grant, explicit output mux, one dead cycle per handover.
// Latency: DMA request at a boundary edge -> HANDOVER next cycle -> grant the cycle after.
// Backpressure: decisions only when bus_ready=1 in OWNED; bus_ready=0 freezes owner/grant/state.
module bus_master_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 5,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RR_MODE     = 0,
    localparam int IDX_W      = $clog2(NUM_MASTERS)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_MASTERS-1:0]             req,
    input  logic [NUM_MASTERS-1:0]             preemptable,
    input  logic [NUM_MASTERS-1:0][ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0][DATA_W-1:0] m_wdata,
    input  logic [NUM_MASTERS-1:0][1:0]        m_size,
    input  logic [NUM_MASTERS-1:0]             m_write,
    input  logic                               bus_ready,
    output logic [ADDR_W-1:0]                  addr,
    output logic [DATA_W-1:0]                  wdata,
    output logic [1:0]                         size,
    output logic                               write,
    output logic                               valid,
    output logic [NUM_MASTERS-1:0]             grant,
    output logic [NUM_MASTERS-1:0]             pause,
    output logic [IDX_W-1:0]                   owner
);

    arb_state_t               state_q, state_d;
    logic [IDX_W-1:0]         owner_q, owner_d;
    logic [NUM_MASTERS-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;

    logic [IDX_W-1:0]         winner;
    logic                     any_dma;
    logic                     boundary;
    logic                     owner_yields;

    arb_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .RR_MODE     (RR_MODE)
    ) u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .winner  (winner),
        .any_dma (any_dma)
    );

    // Ownership FSM: leave OWNED only at a transfer boundary, spend exactly one cycle in HANDOVER.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        boundary     = (state_q == OWNED) && bus_ready;
        owner_yields = !req[owner_q] || preemptable[owner_q];
        case (state_q)
            OWNED: begin
                if (boundary && (winner != owner_q) && owner_yields) begin
                    state_d = HANDOVER;
                    grant_d = '0;
                    // A DMA giving up the bus moves the round-robin start past itself.
                    if (owner_q != IDX_W'(PARK_MASTER)) begin
                        rr_ptr_d = (owner_q == IDX_W'(NUM_MASTERS - 1)) ? IDX_W'(1)
                                                                         : owner_q + IDX_W'(1);
                    end
                end
            end
            HANDOVER: begin
                // Re-arbitrate from this cycle's requests; a vanished target falls back to park.
                state_d = OWNED;
                owner_d = any_dma ? winner : IDX_W'(PARK_MASTER);
                grant_d = NUM_MASTERS'(1) << owner_d;
            end
            default: begin
                state_d = OWNED;
                owner_d = IDX_W'(PARK_MASTER);
                grant_d = NUM_MASTERS'(1) << PARK_MASTER;
            end
        endcase
    end

    // State registers with synchronous reset to the CPU-parked state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= OWNED;
            owner_q  <= IDX_W'(PARK_MASTER);
            grant_q  <= NUM_MASTERS'(1) << PARK_MASTER;
            rr_ptr_q <= IDX_W'(1);
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Output mux: payload comes from the registered owner and is zeroed when nothing valid is driven.
    always_comb begin
        valid = (state_q == OWNED) && req[owner_q];
        addr  = valid ? m_addr[owner_q]  : '0;
        wdata = valid ? m_wdata[owner_q] : '0;
        size  = valid ? m_size[owner_q]  : '0;
        write = valid && m_write[owner_q];
        grant = grant_q;
        owner = owner_q;
        pause = ~grant_q | {NUM_MASTERS{~bus_ready}};
    end

    // Structural invariants of the ownership FSM.
    a_grant_onehot_owned: assert property (@(posedge clock) disable iff (reset)
        (state_q == OWNED) |-> $onehot(grant_q));
    a_grant_zero_handover: assert property (@(posedge clock) disable iff (reset)
        (state_q == HANDOVER) |-> (grant_q == '0));
    a_handover_one_cycle: assert property (@(posedge clock) disable iff (reset)
        (state_q == HANDOVER) |=> (state_q == OWNED));
    a_hold_when_busy: assert property (@(posedge clock) disable iff (reset)
        ((state_q == OWNED) && !bus_ready) |=> ($stable(owner_q) && $stable(grant_q) && (state_q == OWNED)));

endmodule
